// File: rtl/dem_perm_sched.sv
// rtl/dem_perm_sched.sv - per-cycle permutation index scheduler for the 8-element DEM mapper
// Define DEM_PERM_UNIQUE_EN to restrict perm_idx to the 24 distinct permutations (0..23).
module dem_perm_sched #(
  parameter int          FRAME_LEN = 32,
  parameter logic [15:0] SEED_DEF  = 16'hACE1
) (
  input  logic        dem_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        cfg_req,
  input  logic [1:0]  cfg_mode,
  input  logic [4:0]  cfg_step,
  input  logic [4:0]  cfg_fixed,
  input  logic [15:0] cfg_seed,
  output logic        cfg_ack,
  output logic [4:0]  perm_idx,
  output logic        perm_vld,
  output logic        busy,
  output logic        frame_tick
);

  localparam logic [7:0]  CNT_LAST  = 8'(FRAME_LEN - 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] MODE_SEQ  = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_ROT  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PEND} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  mode_q, mode_d;
  logic [4:0]  step_q, step_d;
  logic [4:0]  fixed_q, fixed_d;
  logic [4:0]  perm_idx_q, perm_idx_d;
  logic        cfg_ack_q, cfg_ack_d;

  logic        tick;
  logic        req_ok;
  logic        apply;
  logic [15:0] seed_eff;
  logic [4:0]  fixed_eff;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

`ifdef DEM_PERM_UNIQUE_EN
  function automatic logic [4:0] wrap24(input logic [5:0] v);
    return (v >= 6'd24) ? 5'(v - 6'd24) : v[4:0];
  endfunction

  function automatic logic [4:0] next_idx(input logic [1:0] mode, input logic [4:0] step,
                                          input logic [4:0] fixed, input logic [4:0] idx,
                                          input logic [4:0] lfsr_lo);
    case (mode)
      MODE_SEQ:  return (idx >= 5'd23) ? 5'd0 : idx + 5'd1;
      MODE_LFSR: return wrap24({1'b0, lfsr_lo});
      MODE_ROT:  return wrap24({1'b0, idx} + {1'b0, wrap24({1'b0, step})});
      default:   return fixed;
    endcase
  endfunction

  assign fixed_eff = wrap24({1'b0, cfg_fixed});
`else
  function automatic logic [4:0] next_idx(input logic [1:0] mode, input logic [4:0] step,
                                          input logic [4:0] fixed, input logic [4:0] idx,
                                          input logic [4:0] lfsr_lo);
    case (mode)
      MODE_SEQ:  return idx + 5'd1;
      MODE_LFSR: return lfsr_lo;
      MODE_ROT:  return idx + step;
      default:   return fixed;
    endcase
  endfunction

  assign fixed_eff = cfg_fixed;
`endif

  // A zero seed would lock the LFSR at zero forever.
  assign seed_eff = (cfg_seed == 16'd0) ? SEED_DEF : cfg_seed;
  assign tick     = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
  // The ack cycle still sees the requester's cfg_req high; it must not re-trigger.
  assign req_ok   = cfg_req && !cfg_ack_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    mode_d     = mode_q;
    step_d     = step_q;
    fixed_d    = fixed_q;
    perm_idx_d = perm_idx_q;
    cfg_ack_d  = 1'b0;
    apply      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        perm_idx_d = 5'd0;
        cnt_d      = 8'd0;
        apply      = req_ok;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN, ST_PEND: begin
        if (!enable) begin
          state_d    = ST_IDLE;
          cnt_d      = 8'd0;
          perm_idx_d = 5'd0;
          apply      = (state_q == ST_PEND);
        end else begin
          cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
          if (state_q == ST_PEND && tick) begin
            // New config drives the first index of the next frame.
            apply      = 1'b1;
            state_d    = ST_RUN;
            perm_idx_d = next_idx(cfg_mode, cfg_step, fixed_eff, perm_idx_q, seed_eff[4:0]);
          end else begin
            if (mode_q == MODE_LFSR) lfsr_d = lfsr_step(lfsr_q);
            perm_idx_d = next_idx(mode_q, step_q, fixed_q, perm_idx_q, lfsr_d[4:0]);
            if (state_q == ST_RUN && req_ok) state_d = ST_PEND;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cnt_d      = 8'd0;
        perm_idx_d = 5'd0;
      end
    endcase

    if (apply) begin
      mode_d    = cfg_mode;
      step_d    = cfg_step;
      fixed_d   = fixed_eff;
      lfsr_d    = seed_eff;
      cfg_ack_d = 1'b1;
    end
  end

  always_ff @(posedge dem_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      lfsr_q     <= SEED_DEF;
      mode_q     <= MODE_SEQ;
      step_q     <= 5'd1;
      fixed_q    <= 5'd0;
      perm_idx_q <= 5'd0;
      cfg_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      fixed_q    <= fixed_d;
      perm_idx_q <= perm_idx_d;
      cfg_ack_q  <= cfg_ack_d;
    end
  end

  assign perm_idx   = perm_idx_q;
  assign perm_vld   = (state_q != ST_IDLE);
  assign busy       = (state_q == ST_PEND);
  assign frame_tick = tick;
  assign cfg_ack    = cfg_ack_q;

endmodule
